// File: rtl/wave_scope_mapper.sv
// wave_scope_mapper: double-buffered triggered sample capture rendered as VGA waveform pixels
module wave_scope_mapper #(
  parameter int NCH        = 2,
  parameter int SAMPLE_W   = 8,
  parameter int GAIN_SHIFT = 1,
  parameter int H_RES      = 640,
  parameter int V_RES      = 480
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      sample_valid,
  input  logic [NCH*SAMPLE_W-1:0]   sample_data,
  input  logic                      trig_en,
  input  logic                      freeze,
  input  logic [9:0]                DrawX,
  input  logic [9:0]                DrawY,
  output logic [3:0]                Red,
  output logic [3:0]                Green,
  output logic [3:0]                Blue,
  output logic                      capture_done
);
  localparam int AW = $clog2(H_RES);
  localparam int DW = NCH * SAMPLE_W;
  localparam int YW = SAMPLE_W + GAIN_SHIFT + 2;
  localparam logic signed [YW-1:0] Y0 = YW'(240);
  localparam logic signed [YW-1:0] YMAX = YW'(V_RES - 1);
  typedef enum logic [1:0] {ARMED, CAPTURE, HOLD} state_t;
  state_t state;
  logic [AW-1:0] wr_ptr, rd_addr;
  logic [SAMPLE_W-1:0] prev, ch0;
  logic front_valid, bsel, fv, start, we, last;
  logic [DW-1:0] mem [2][H_RES];
  logic [DW-1:0] rd_data;
  logic [9:0] dx, dy;
  logic [NCH-1:0] on_n;
  logic [3:0] on;
  logic [11:0] rgb;
  assign ch0 = sample_data[SAMPLE_W-1:0];
  assign start = !trig_en || (!ch0[SAMPLE_W-1] && prev[SAMPLE_W-1]);
  assign we = sample_valid && (state == CAPTURE || (state == ARMED && start));
  assign last = wr_ptr == AW'(H_RES - 1);
  assign rd_addr = ({1'b0, DrawX} < 11'(H_RES)) ? AW'(DrawX) : '0;
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= ARMED;
      wr_ptr <= '0;
      prev <= '0;
      front_valid <= 1'b0;
      bsel <= 1'b0;
      capture_done <= 1'b0;
    end else begin
      capture_done <= we && last;
      if (sample_valid) prev <= ch0;
      if (we) begin
        wr_ptr <= last ? '0 : wr_ptr + 1'b1;
        state <= last ? HOLD : CAPTURE;
        if (last) begin
          bsel <= !bsel;
          front_valid <= 1'b1;
        end
      end else if (state == HOLD && !freeze) begin
        state <= ARMED;
      end
    end
  end
  always_ff @(posedge Clk) begin
    if (we) mem[!bsel][wr_ptr] <= sample_data;
    rd_data <= mem[bsel][rd_addr];
  end
  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic signed [YW-1:0] y;
    logic [9:0] yc;
    assign y = Y0 - (YW'($signed(rd_data[k*SAMPLE_W +: SAMPLE_W])) <<< GAIN_SHIFT);
    assign yc = y[YW-1] ? 10'd0 : (y > YMAX) ? 10'(V_RES - 1) : 10'(y);
    assign on_n[k] = fv && ((yc <= 10'd240) ? (dy >= yc && dy <= 10'd240) : (dy >= 10'd240 && dy <= yc));
  end
  assign on = 4'(on_n);
  assign rgb = !({1'b0, dx} < 11'(H_RES) && {1'b0, dy} < 11'(V_RES)) ? 12'h000 :
               on[0] ? 12'h0F0 :
               on[1] ? 12'hFF0 :
               on[2] ? 12'h0FF :
               on[3] ? 12'hF0F :
               (dy == 10'd240) ? 12'h888 :
               (dx % 10'd80 == 10'd0 || dy % 10'd60 == 10'd0) ? 12'h444 : 12'h000;
  always_ff @(posedge Clk) begin
    if (Reset) begin
      dx <= '0;
      dy <= '0;
      fv <= 1'b0;
      {Red, Green, Blue} <= '0;
    end else begin
      dx <= DrawX;
      dy <= DrawY;
      fv <= front_valid;
      {Red, Green, Blue} <= rgb;
    end
  end
endmodule

// File: tb/tb_wave_scope_mapper.sv
// tb_wave_scope_mapper: directed checks of capture, triggering, freeze, reset and pixel colouring
module tb_wave_scope_mapper;
  logic Clk = 1'b0, Reset = 1'b1, sample_valid = 1'b0, trig_en = 1'b0, freeze = 1'b0;
  logic [15:0] sample_data = '0;
  logic [9:0] DrawX = '0, DrawY = '0;
  logic [3:0] Red, Green, Blue;
  logic capture_done;
  int n_run = 0, n_fail = 0, done_cnt = 0, base = 0;
  wave_scope_mapper dut (
    .Clk(Clk), .Reset(Reset), .sample_valid(sample_valid), .sample_data(sample_data),
    .trig_en(trig_en), .freeze(freeze), .DrawX(DrawX), .DrawY(DrawY),
    .Red(Red), .Green(Green), .Blue(Blue), .capture_done(capture_done)
  );
  always #5 Clk = ~Clk;
  always @(posedge Clk) if (capture_done) done_cnt++;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge Clk);
    #1;
  endtask
  task automatic send(input int c0, input int c1);
    sample_data = {8'(c1), 8'(c0)};
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
  endtask
  task automatic send_n(input int n, input int c0, input int c1);
    repeat (n) send(c0, c1);
  endtask
  task automatic pix(input string tag, input int x, input int y, input logic [11:0] exp);
    DrawX = 10'(x);
    DrawY = 10'(y);
    step();
    step();
    check(tag, {20'd0, Red, Green, Blue}, {20'd0, exp});
  endtask
  initial begin
    step();
    step();
    check("rst_rgb", {20'd0, Red, Green, Blue}, 0);
    check("rst_done", {31'd0, capture_done}, 0);
    Reset = 1'b0;
    pix("center", 0, 240, 12'h888);
    pix("grid_y60", 81, 60, 12'h444);
    pix("black", 81, 61, 12'h000);
    pix("grid_x80", 80, 10, 12'h444);
    pix("off_x", 640, 240, 12'h000);
    pix("off_y", 5, 480, 12'h000);
    base = done_cnt;
    send_n(639, 20, -10);
    check("done_early", {31'd0, capture_done}, 0);
    send(20, -10);
    check("done_pulse", {31'd0, capture_done}, 1);
    step();
    check("done_width", {31'd0, capture_done}, 0);
    check("done_cnt_free", done_cnt - base, 1);
    pix("ch0_top", 5, 200, 12'h0F0);
    pix("ch1_mid", 5, 250, 12'hFF0);
    pix("ch0_prio", 5, 240, 12'h0F0);
    pix("ch0_above", 5, 199, 12'h000);
    pix("ch1_below", 5, 261, 12'h000);
    send_n(640, 127, 0);
    step();
    pix("clamp_top", 5, 0, 12'h0F0);
    pix("clamp_top_c", 5, 240, 12'h0F0);
    pix("clamp_top_b", 5, 241, 12'h000);
    send_n(640, -128, 0);
    step();
    pix("clamp_bot", 5, 479, 12'h0F0);
    pix("clamp_bot_a", 5, 239, 12'h000);
    trig_en = 1'b1;
    send(-5, 0);
    send(-3, 0);
    base = done_cnt;
    send(2, 0);
    send_n(639, 50, 0);
    step();
    check("done_cnt_trig", done_cnt - base, 1);
    pix("trig_addr0", 0, 237, 12'h0F0);
    pix("trig_addr0_g", 0, 200, 12'h444);
    pix("trig_addr1", 1, 150, 12'h0F0);
    base = done_cnt;
    send_n(100, 10, 0);
    send_n(100, -10, 0);
    step();
    check("no_cross", done_cnt - base, 0);
    pix("no_cross_pix", 0, 237, 12'h0F0);
    trig_en = 1'b0;
    base = done_cnt;
    send_n(300, 30, 0);
    freeze = 1'b1;
    send_n(340, 30, 0);
    step();
    check("frz_complete", done_cnt - base, 1);
    send_n(640, -30, 0);
    step();
    check("frz_hold", done_cnt - base, 1);
    pix("frz_kept", 5, 190, 12'h0F0);
    pix("frz_ignored", 5, 290, 12'h000);
    freeze = 1'b0;
    step();
    base = done_cnt;
    send_n(640, -30, 0);
    step();
    check("rearm", done_cnt - base, 1);
    pix("rearm_pix", 5, 290, 12'h0F0);
    pix("pre_rst", 5, 260, 12'h0F0);
    send_n(300, 60, 0);
    Reset = 1'b1;
    step();
    check("mid_rst_rgb", {20'd0, Red, Green, Blue}, 0);
    check("mid_rst_done", {31'd0, capture_done}, 0);
    Reset = 1'b0;
    pix("rst_no_wave", 5, 260, 12'h000);
    pix("rst_center", 0, 240, 12'h888);
    base = done_cnt;
    send_n(639, 60, 0);
    check("rst_restart_early", done_cnt - base, 0);
    send(60, 0);
    step();
    check("rst_restart", done_cnt - base, 1);
    pix("rst_new_frame", 5, 150, 12'h0F0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
